segment_scan: RTL and testbench
===============================

Name: segment_scan

Overview:
- Parametrised time-multiplexed driver for a common-anode 7-segment display bank.
- Successor to the static single-digit decoder. It scans NUM_DIGITS digits one at a time and decodes the full hex set.
- Adds per-digit decimal points, per-digit blanking and a double-buffered display frame, so updates never tear mid-scan.
- Sits between the application's BCD/hex value registers and the board's segment/digit pins.

Parameters:
- NUM_DIGITS, 8, digits scanned; legal range 1..16.
- SCAN_DIV, 50000, clock cycles each digit stays selected; legal minimum 2.
- BLANK_CYCLES, 2, leading cycles of each digit slot forced dark; used only when GHOST_BLANK_EN is defined; must be < SCAN_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data  input  4*NUM_DIGITS  hex nibble per digit; digit i = data[4i+3:4i]
- dp  input  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_en  input  NUM_DIGITS  1 = digit displayed, 0 = blanked
- load  input  1  one-cycle strobe; captures data/dp/digit_en into the pending buffer
- segment  output  8  active-low segments: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- select  output  NUM_DIGITS  active-high one-hot digit select; select[i] drives digit i
- frame_done  output  1  one-cycle pulse on the cycle the scan wraps from the last digit to digit 0
- update_pending  output  1  high while a loaded frame waits to become active

Behaviour:
- Reset (async assert, sync release):
  - segment=8'hFF, select=0, frame_done=0, update_pending=0.
  - Divider=0, digit index=0.
  - Pending and active buffers cleared (data=0, dp=0, digit_en=0), so the display is dark until the first load takes effect.
- Divider counts 0..SCAN_DIV-1.
  - At terminal count it returns to 0 and the index advances.
  - Index wraps from NUM_DIGITS-1 to 0. Each slot lasts exactly SCAN_DIV cycles.
- Frame wrap = divider terminal count while index = NUM_DIGITS-1.
  - frame_done is registered and high for exactly the first cycle of the new digit-0 slot.
  - If NUM_DIGITS=1, frame_done pulses every SCAN_DIV cycles.
- All outputs are registered. select and segment change on the same clock edge, with no intermediate glitch state.
- Slot for digit i:
  - If active digit_en[i]=1: select = one-hot bit i; segment[7:1] = hex decode of active nibble i; segment[0] = ~active dp[i].
  - If active digit_en[i]=0: select=0, segment=8'hFF. The slot time is still consumed, so brightness stays uniform.
- Decode, written as segment[7:1] (0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Double buffering:
  - load copies inputs to the pending buffer and sets update_pending.
  - At frame wrap, if update_pending=1, pending is copied to active and update_pending clears. The new frame is first visible in the digit-0 slot.
  - A further load before the wrap overwrites pending; last load wins.
  - A load in the same cycle as frame wrap bypasses pending: the inputs go straight to active and update_pending stays 0.
- Reset mid-scan: outputs go dark immediately (async). After release, scanning restarts at digit 0 with the divider at 0.

Optional Feature:
- Macro GHOST_BLANK_EN.
- Defined: during divider values 0..BLANK_CYCLES-1 of every slot, select=0 and segment=8'hFF (anti-ghosting dead time). The rest of the slot behaves as normal. frame_done timing is unchanged.
- Not defined: no dead time. BLANK_CYCLES is ignored and the slot is lit for all SCAN_DIV cycles.

Test Plan:
- Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, feature off unless stated.
- Reset, then no load -> segment=8'hFF and select=4'b0000 for 32 cycles; frame_done pulses every 16 cycles.
- load with data=16'h3210, dp=4'b0100, digit_en=4'hF -> from the next frame wrap, select walks 0001,0010,0100,1000 at 4 cycles each; segment = 03,9F,24,0D (dp lit on digit 2).
- load of all values A..F across two loads, checked against the decode table (e.g. A=8'h11, F=8'h71); digit_en=4'b1010 -> slots 0 and 2 show select=0, segment=FF.
- Two loads in one frame (16'h1111, then 16'h2222) -> only 2 is ever displayed; update_pending=1 between the load and the wrap, and 0 after it.
- load coincident with frame wrap -> new data shown in the digit-0 slot immediately; update_pending never rises. Assert rst_n mid-slot 2 -> outputs dark in the same cycle; after release, digit 0 is selected.
- GHOST_BLANK_EN defined, BLANK_CYCLES=1 -> each 4-cycle slot shows 1 dark cycle then 3 lit cycles; frame_done period is still 16 cycles.

Source files
------------

// File: rtl/segment_scan.sv
// -----------------------------------------------------------------------------
// segment_scan
//   Time-multiplexed driver for a bank of common-anode 7-segment digits.
//   Each digit is selected for SCAN_DIV cycles in turn. A full hex decoder,
//   per-digit decimal points and per-digit blanking are supported.
//   The displayed frame is double buffered. A load only reaches the active
//   buffer at a frame wrap, so a scan never shows a mix of two frames.
//
//   Optional build macro: GHOST_BLANK_EN
//     When defined, the first BLANK_CYCLES cycles of every digit slot are
//     forced dark. This dead time suppresses ghosting between digits.
//     When undefined, BLANK_CYCLES is ignored.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset (released synchronously upstream)
//   data           4*NUM_DIGITS hex nibbles; digit i = data[4i+3:4i]
//   dp             decimal point per digit, 1 = lit
//   digit_en       1 = digit displayed, 0 = blanked
//   load           one-cycle strobe, captures data/dp/digit_en
//   segment        active-low segments {a,b,c,d,e,f,g,dp}
//   select         active-high one-hot digit select
//   frame_done     one-cycle pulse in the first cycle of a new digit-0 slot
//   update_pending high while a loaded frame waits for the next frame wrap
//
// Handshake: load is a plain strobe with no ready. Every cycle with load=1
//   is accepted. The last load before a wrap wins.
// -----------------------------------------------------------------------------
module segment_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   select,
    output logic                    frame_done,
    output logic                    update_pending
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Segment pattern {a..g}, 0 = lit.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scan position
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap;

    // Pending and active frame buffers
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic                    up_q, up_d;

    // Registered outputs
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fd_q;
    logic                  lit;
    logic [3:0]            nib;

    assign wrap = (div_q == DIV_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        div_d       = div_q + 1'b1;
        idx_d       = idx_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_en_d    = act_en_q;
        up_d        = up_q;
        lit         = 1'b0;
        nib         = 4'h0;
        seg_d       = 8'hFF;
        sel_d       = '0;

        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load on the wrap cycle skips the pending stage entirely.
        if (load && wrap) begin
            act_data_d = data;
            act_dp_d   = dp;
            act_en_d   = digit_en;
            up_d       = 1'b0;
        end else if (load) begin
            pend_data_d = data;
            pend_dp_d   = dp;
            pend_en_d   = digit_en;
            up_d        = 1'b1;
        end else if (wrap && up_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_en_d   = pend_en_q;
            up_d       = 1'b0;
        end

        // Outputs are computed from the next scan position and the next
        // active frame. The registered outputs then line up with the
        // counters in the same cycle, and select/segment switch together.
        nib = act_data_d[{idx_d, 2'b00} +: 4];
        lit = act_en_d[idx_d];
`ifdef GHOST_BLANK_EN
        if (div_d < DIV_W'(BLANK_CYCLES)) lit = 1'b0;
`endif
        if (lit) begin
            seg_d = {hex_decode(nib), ~act_dp_d[idx_d]};
            sel_d = NUM_DIGITS'(1) << idx_d;
        end
    end

`ifndef GHOST_BLANK_EN
    logic unused_blank;
    assign unused_blank = ^BLANK_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
            up_q        <= 1'b0;
            seg_q       <= 8'hFF;
            sel_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_en_q   <= pend_en_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_en_q    <= act_en_d;
            up_q        <= up_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            fd_q        <= wrap;
        end
    end

    assign segment        = seg_q;
    assign select         = sel_q;
    assign frame_done     = fd_q;
    assign update_pending = up_q;

endmodule

// File: tb/tb_segment_scan.sv
module tb_segment_scan;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int P  = N * SD;
`ifdef GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [4*N-1:0] data;
    logic [N-1:0]   dp, digit_en;
    logic           load;
    logic [7:0]     segment;
    logic [N-1:0]   select;
    logic           frame_done, update_pending;

    segment_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .digit_en(digit_en),
        .load(load), .segment(segment), .select(select),
        .frame_done(frame_done), .update_pending(update_pending)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t counts cycles since reset release; the scan position follows
    // directly from it by division.
    logic [6:0]     dec_tab [16];
    int             m_t = 0;
    logic [4*N-1:0] m_act_data = '0, m_pend_data = '0;
    logic [N-1:0]   m_act_dp = '0, m_act_en = '0, m_pend_dp = '0, m_pend_en = '0;
    logic           m_pend = 1'b0;

    initial begin
        dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0;
            m_act_data = '0; m_act_dp = '0; m_act_en = '0;
            m_pend_data = '0; m_pend_dp = '0; m_pend_en = '0;
            m_pend = 1'b0;
        end else begin
            if (load && (m_t % P == P - 1)) begin
                m_act_data = data; m_act_dp = dp; m_act_en = digit_en;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend_data = data; m_pend_dp = dp; m_pend_en = digit_en;
                m_pend = 1'b1;
            end else if ((m_t % P == P - 1) && m_pend) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
                m_pend = 1'b0;
            end
            m_t++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int idx, ph;
        logic ex_lit;
        logic [7:0] ex_seg;
        logic [N-1:0] ex_sel;
        logic ex_fd;
        idx    = (m_t / SD) % N;
        ph     = m_t % SD;
        ex_lit = rst_n && m_act_en[idx] && !(GHOST && ph < BC);
        ex_seg = 8'hFF;
        ex_sel = '0;
        if (ex_lit) begin
            ex_seg = {dec_tab[m_act_data[4*idx +: 4]], ~m_act_dp[idx]};
            ex_sel = N'(1) << idx;
        end
        ex_fd = rst_n && (m_t > 0) && (m_t % P == 0);
        check("segment", 32'(segment), 32'(ex_seg));
        check("select", 32'(select), 32'(ex_sel));
        check("frame_done", 32'(frame_done), 32'(ex_fd));
        check("update_pending", 32'(update_pending), 32'(rst_n && m_pend));
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        @(negedge clk);
        if (m_t % P == P - 1) @(negedge clk);
        data = d; dp = p; digit_en = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns at the negedge of the first cycle of a digit-0 slot.
    task automatic wait_wrap();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (m_t % P != 0 && k < 200);
        if (k >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL wait_wrap: timeout after %0d cycles", k);
        end
    endtask

    // Literal checks of one frame, sampled in the last cycle of each slot.
    task automatic check_frame(input logic [31:0] segs, input logic [15:0] sels);
        wait_wrap();
`ifdef GHOST_BLANK_EN
        check("ghost_dark_sel", 32'(select), 32'h0);
        check("ghost_dark_seg", 32'(segment), 32'hFF);
`endif
        for (int i = 0; i < N; i++) begin
            repeat (SD - 1) @(negedge clk);
            check("lit_seg", 32'(segment), 32'(segs[8*i +: 8]));
            check("lit_sel", 32'(select), 32'(sels[4*i +: 4]));
            if (i < N - 1) @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses, k;
        data = '0; dp = '0; digit_en = '0; load = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle: dark display, frame_done every 16 cycles.
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
        check("idle_pulses", 32'(pulses), 32'd2);
        check("idle_seg", 32'(segment), 32'hFF);

        // Digits 0..3 with the dp on digit 2.
        do_load(16'h3210, 4'b0100, 4'hF);
        check("pend_after_load", 32'(update_pending), 32'd1);
        check_frame(32'h0D249F03, 16'h8421);

        // A..D, then E/F with digits 0 and 2 blanked.
        do_load(16'hDCBA, 4'b0000, 4'hF);
        check_frame(32'h8563C111, 16'h8421);
        do_load(16'hF0E0, 4'b0000, 4'b1010);
        check_frame(32'h71FF61FF, 16'h8020);

        // Two loads in one frame: last wins.
        wait_wrap();
        do_load(16'h1111, 4'b0000, 4'hF);
        do_load(16'h2222, 4'b0000, 4'hF);
        check("two_load_pending", 32'(update_pending), 32'd1);
        check_frame(32'h25252525, 16'h8421);
        check("two_load_cleared", 32'(update_pending), 32'd0);

        // Load coincident with the wrap goes straight to active.
        k = 0;
        do begin @(negedge clk); k++; end while (m_t % P != P - 1 && k < 200);
        data = 16'h7777; dp = 4'b0000; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bypass_pending", 32'(update_pending), 32'd0);
        repeat (SD - 1) @(negedge clk);
        check("bypass_seg", 32'(segment), 32'h1F);
        check("bypass_sel", 32'(select), 32'h1);

        // Reset in the middle of the digit-2 slot.
        k = 0;
        do begin @(negedge clk); k++; end
        while (!(((m_t / SD) % N == 2) && (m_t % SD == 1)) && k < 200);
        check("pre_reset_sel", 32'(select), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("reset_seg", 32'(segment), 32'hFF);
        check("reset_sel", 32'(select), 32'h0);
        check("reset_pending", 32'(update_pending), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(16'h3210, 4'b0000, 4'hF);
        check_frame(32'h0D259F03, 16'h8421);

        // Randomized loads checked every cycle by the compare process.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                data = 16'($urandom);
                dp = 4'($urandom_range(0, 15));
                digit_en = 4'($urandom_range(0, 15));
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
